// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/flush controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } ctrl_state_t;

    localparam int unsigned PR_IF_ID   = 0;
    localparam int unsigned PR_ID_EX   = 1;
    localparam int unsigned MASK_MAX_W = 32;

    // Bubble mask covering every pipeline register younger than the branch stage.
    function automatic logic [MASK_MAX_W-1:0] flush_mask(input int unsigned bj_stage);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_MAX_W; i++) begin
            if (i < int'(bj_stage)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             INC,
    output logic [WIDTH-1:0] COUNT
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (INC && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule

// File: rtl/pipeline_control_unit.sv
// Hazard/flush controller: priority-resolved hold/bubble controls, cache-switch
// drain sequencing and saturating stall/flush performance counters.
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned BJ_STAGE     = 2,
    parameter int unsigned DRAIN_CYCLES = NUM_STAGES - 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  HAZARD_DETECT,
    input  logic                  BJ_MUX_SELECT,
    input  logic                  IMEM_BUSY,
    input  logic                  DMEM_BUSY,
    input  logic                  SWITCH_REQ,
    input  logic                  SWITCH_DONE,
    output logic                  HOLD_PC,
    output logic [NUM_STAGES-2:0] HOLD_PR,
    output logic [NUM_STAGES-2:0] RESET_PR,
    output logic                  SWITCH_ACK,
    output logic [CNT_WIDTH-1:0]  STALL_COUNT,
    output logic [CNT_WIDTH-1:0]  FLUSH_COUNT
);

    localparam int unsigned PR_W = NUM_STAGES - 1;
    localparam int unsigned DC_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [PR_W-1:0] FLUSH_MASK = PR_W'(flush_mask(BJ_STAGE));

    ctrl_state_t     state_q;
    ctrl_state_t     state_d;
    logic [DC_W-1:0] drain_q;
    logic [DC_W-1:0] drain_d;

    logic            rule_freeze;
    logic            rule_flush;
    logic            rule_hazard;
    logic            rule_fetch;
    logic            bubble_c;
    logic            hold_pc_c;
    logic [PR_W-1:0] hold_pr_c;
    logic [PR_W-1:0] reset_pr_c;
    logic            switch_ack_c;

    assign rule_freeze = DMEM_BUSY;
    assign rule_flush  = !DMEM_BUSY && BJ_MUX_SELECT;
    assign rule_hazard = !DMEM_BUSY && !BJ_MUX_SELECT && HAZARD_DETECT;
    assign rule_fetch  = !DMEM_BUSY && !BJ_MUX_SELECT && !HAZARD_DETECT && IMEM_BUSY;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        hold_pc_c    = 1'b0;
        hold_pr_c    = '0;
        reset_pr_c   = '0;
        switch_ack_c = 1'b0;
        bubble_c     = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;

        // Base priority rules shared by every state.
        if (rule_freeze) begin
            hold_pc_c = 1'b1;
            hold_pr_c = '1;
        end else if (rule_flush) begin
            reset_pr_c = FLUSH_MASK;
        end else if (rule_hazard) begin
            hold_pc_c            = 1'b1;
            hold_pr_c[PR_IF_ID]  = 1'b1;
            reset_pr_c[PR_ID_EX] = 1'b1;
        end else if (rule_fetch) begin
            hold_pc_c            = 1'b1;
            reset_pr_c[PR_IF_ID] = 1'b1;
        end

        case (state_q)
            RUN: begin
                if (SWITCH_REQ) begin
                    state_d = DRAIN;
                    drain_d = DC_W'(DRAIN_CYCLES);
                end
            end
            DRAIN: begin
                // Stop fetching and keep injecting bubbles until older work retires.
                if (!rule_flush) begin
                    hold_pc_c = 1'b1;
                end
                if (!(rule_freeze || rule_hazard)) begin
                    reset_pr_c[PR_IF_ID] = 1'b1;
                end
                bubble_c = reset_pr_c[PR_IF_ID] && !DMEM_BUSY;
                if (bubble_c) begin
                    drain_d = drain_q - DC_W'(1);
                    if (drain_q == DC_W'(1)) begin
                        state_d = SWITCH;
                    end
                end
            end
            SWITCH: begin
                // Front end stays empty; older stages still obey the base rules.
                hold_pc_c            = 1'b1;
                hold_pr_c[PR_IF_ID]  = 1'b0;
                reset_pr_c[PR_IF_ID] = 1'b1;
                switch_ack_c         = 1'b1;
                if (SWITCH_DONE) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                drain_d = '0;
            end
        endcase

        if (!RESET) begin
            hold_pc_c    = 1'b0;
            hold_pr_c    = '0;
            reset_pr_c   = '1;
            switch_ack_c = 1'b0;
        end
    end

    assign HOLD_PC    = hold_pc_c;
    assign HOLD_PR    = hold_pr_c;
    assign RESET_PR   = reset_pr_c;
    assign SWITCH_ACK = switch_ack_c;

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (hold_pc_c),
        .COUNT (STALL_COUNT)
    );

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .INC   (rule_flush),
        .COUNT (FLUSH_COUNT)
    );

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Bench for pipeline_control_unit: three parameterisations driven in lockstep
// and compared against a rule-level reference model every cycle.
module tb_pipeline_control_unit;

    logic CLK;
    logic RESET, HAZARD_DETECT, BJ_MUX_SELECT, IMEM_BUSY, DMEM_BUSY, SWITCH_REQ, SWITCH_DONE;

    logic        hpc0, ack0, hpc1, ack1, hpc2, ack2;
    logic [3:0]  hpr0, rpr0, hpr1, rpr1;
    logic [5:0]  hpr2, rpr2;
    logic [31:0] st0, fl0, st2, fl2;
    logic [3:0]  st1, fl1;

    int tests = 0;
    int fails = 0;

    int ns_p [3] = '{5, 5, 7};
    int bj_p [3] = '{2, 2, 3};
    int dc_p [3] = '{4, 4, 6};
    int cw_p [3] = '{32, 4, 32};

    // Model: mode 0 = running, 1 = draining, 2 = switch granted.
    int     m_mode  [3];
    int     m_rem   [3];
    longint m_stall [3];
    longint m_flush [3];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    pipeline_control_unit u_d0 (
        .CLK(CLK), .RESET(RESET), .HAZARD_DETECT(HAZARD_DETECT), .BJ_MUX_SELECT(BJ_MUX_SELECT),
        .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY), .SWITCH_REQ(SWITCH_REQ), .SWITCH_DONE(SWITCH_DONE),
        .HOLD_PC(hpc0), .HOLD_PR(hpr0), .RESET_PR(rpr0), .SWITCH_ACK(ack0),
        .STALL_COUNT(st0), .FLUSH_COUNT(fl0));

    pipeline_control_unit #(.CNT_WIDTH(4)) u_d1 (
        .CLK(CLK), .RESET(RESET), .HAZARD_DETECT(HAZARD_DETECT), .BJ_MUX_SELECT(BJ_MUX_SELECT),
        .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY), .SWITCH_REQ(SWITCH_REQ), .SWITCH_DONE(SWITCH_DONE),
        .HOLD_PC(hpc1), .HOLD_PR(hpr1), .RESET_PR(rpr1), .SWITCH_ACK(ack1),
        .STALL_COUNT(st1), .FLUSH_COUNT(fl1));

    pipeline_control_unit #(.NUM_STAGES(7), .BJ_STAGE(3)) u_d2 (
        .CLK(CLK), .RESET(RESET), .HAZARD_DETECT(HAZARD_DETECT), .BJ_MUX_SELECT(BJ_MUX_SELECT),
        .IMEM_BUSY(IMEM_BUSY), .DMEM_BUSY(DMEM_BUSY), .SWITCH_REQ(SWITCH_REQ), .SWITCH_DONE(SWITCH_DONE),
        .HOLD_PC(hpc2), .HOLD_PR(hpr2), .RESET_PR(rpr2), .SWITCH_ACK(ack2),
        .STALL_COUNT(st2), .FLUSH_COUNT(fl2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected control outputs from the priority rules and the per-state overlays.
    function automatic void mout(input int k, output bit hpc, output bit [7:0] hpr,
                                 output bit [7:0] rpr, output bit ack);
        int n;
        int rule;
        n   = ns_p[k] - 1;
        hpc = 1'b0;
        hpr = '0;
        rpr = '0;
        ack = 1'b0;
        if (!RESET) begin
            for (int i = 0; i < n; i++) rpr[i] = 1'b1;
            return;
        end
        rule = DMEM_BUSY ? 1 : BJ_MUX_SELECT ? 2 : HAZARD_DETECT ? 3 : IMEM_BUSY ? 4 : 5;
        case (rule)
            1: begin hpc = 1'b1; for (int i = 0; i < n; i++) hpr[i] = 1'b1; end
            2: for (int i = 0; i < bj_p[k]; i++) rpr[i] = 1'b1;
            3: begin hpc = 1'b1; hpr[0] = 1'b1; rpr[1] = 1'b1; end
            4: begin hpc = 1'b1; rpr[0] = 1'b1; end
            default: ;
        endcase
        if (m_mode[k] == 1) begin
            hpc = (rule != 2);
            if (rule != 1 && rule != 3) rpr[0] = 1'b1;
        end else if (m_mode[k] == 2) begin
            hpc    = 1'b1;
            hpr[0] = 1'b0;
            rpr[0] = 1'b1;
            ack    = 1'b1;
        end
    endfunction

    task automatic check_all();
        bit hpc, ack;
        bit [7:0] hpr, rpr;
        logic [63:0] o_hpc, o_hpr, o_rpr, o_ack, o_st, o_fl;
        for (int k = 0; k < 3; k++) begin
            mout(k, hpc, hpr, rpr, ack);
            case (k)
                0: begin o_hpc = 64'(hpc0); o_hpr = 64'(hpr0); o_rpr = 64'(rpr0); o_ack = 64'(ack0);
                         o_st = 64'(st0); o_fl = 64'(fl0); end
                1: begin o_hpc = 64'(hpc1); o_hpr = 64'(hpr1); o_rpr = 64'(rpr1); o_ack = 64'(ack1);
                         o_st = 64'(st1); o_fl = 64'(fl1); end
                default: begin o_hpc = 64'(hpc2); o_hpr = 64'(hpr2); o_rpr = 64'(rpr2); o_ack = 64'(ack2);
                         o_st = 64'(st2); o_fl = 64'(fl2); end
            endcase
            chk($sformatf("d%0d HOLD_PC", k), o_hpc, 64'(hpc));
            chk($sformatf("d%0d HOLD_PR", k), o_hpr, 64'(hpr));
            chk($sformatf("d%0d RESET_PR", k), o_rpr, 64'(rpr));
            chk($sformatf("d%0d SWITCH_ACK", k), o_ack, 64'(ack));
            chk($sformatf("d%0d STALL_COUNT", k), o_st, 64'(m_stall[k]));
            chk($sformatf("d%0d FLUSH_COUNT", k), o_fl, 64'(m_flush[k]));
        end
    endtask

    task automatic drive(input bit rst, input bit hz, input bit bjm, input bit im,
                         input bit dm, input bit req, input bit done);
        RESET = rst; HAZARD_DETECT = hz; BJ_MUX_SELECT = bjm; IMEM_BUSY = im;
        DMEM_BUSY = dm; SWITCH_REQ = req; SWITCH_DONE = done;
        #4;
        check_all();
    endtask

    // Advance one clock and move the model along using the inputs of that cycle.
    task automatic tick();
        bit hpc, ack;
        bit [7:0] hpr, rpr;
        longint mx;
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            mout(k, hpc, hpr, rpr, ack);
            mx = (longint'(1) <<< cw_p[k]) - 1;
            if (!RESET) begin
                m_mode[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else begin
                if (hpc && m_stall[k] < mx) m_stall[k]++;
                if (BJ_MUX_SELECT && !DMEM_BUSY && m_flush[k] < mx) m_flush[k]++;
                case (m_mode[k])
                    0: if (SWITCH_REQ) begin m_mode[k] = 1; m_rem[k] = dc_p[k]; end
                    1: if (rpr[0] && !DMEM_BUSY) begin
                           m_rem[k]--;
                           if (m_rem[k] == 0) m_mode[k] = 2;
                       end
                    default: if (SWITCH_DONE) m_mode[k] = 0;
                endcase
            end
        end
        #1;
    endtask

    initial begin
        RESET = 1'b0; HAZARD_DETECT = 1'b0; BJ_MUX_SELECT = 1'b0; IMEM_BUSY = 1'b0;
        DMEM_BUSY = 1'b0; SWITCH_REQ = 1'b0; SWITCH_DONE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_mode[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
        end
        #6;

        // Reset: forced outputs and cleared counters.
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst RESET_PR d0", 64'(rpr0), 64'h0F);
        chk("rst RESET_PR d2", 64'(rpr2), 64'h3F);
        chk("rst HOLD_PC d0", 64'(hpc0), 64'h0);
        tick();
        drive(0, 1, 1, 1, 1, 1, 0);
        chk("rst busy RESET_PR d0", 64'(rpr0), 64'h0F);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("post-rst STALL d0", 64'(st0), 64'h0);
        chk("post-rst FLUSH d0", 64'(fl0), 64'h0);
        tick();

        // Lone branch flush.
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("bj RESET_PR d0", 64'(rpr0), 64'h03);
        chk("bj HOLD_PC d0", 64'(hpc0), 64'h0);
        chk("bj RESET_PR d2", 64'(rpr2), 64'h07);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("bj FLUSH d0", 64'(fl0), 64'h1);
        tick();

        // Load-use hazard beats fetch stall.
        drive(1, 1, 0, 1, 0, 0, 0);
        chk("hz HOLD_PC d0", 64'(hpc0), 64'h1);
        chk("hz HOLD_PR d0", 64'(hpr0), 64'h1);
        chk("hz RESET_PR d0", 64'(rpr0), 64'h2);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("hz STALL d0", 64'(st0), 64'h1);
        tick();

        // Freeze holds a pending branch, then the branch is applied.
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 1, 0, 1, 0, 0);
            chk("frz HOLD_PR d0", 64'(hpr0), 64'hF);
            chk("frz FLUSH d0", 64'(fl0), 64'h1);
            tick();
        end
        drive(1, 0, 1, 0, 0, 0, 0);
        chk("frz release RESET_PR d0", 64'(rpr0), 64'h3);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("frz release FLUSH d0", 64'(fl0), 64'h2);
        tick();

        // Cache-switch drain with one frozen cycle.
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();
        for (int c = 1; c <= 5; c++) begin
            drive(1, 0, 0, 0, (c == 2), 0, 0);
            chk("drain ACK d0", 64'(ack0), 64'h0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("sw ACK d0", 64'(ack0), 64'h1);
        chk("sw ACK d2 still draining", 64'(ack2), 64'h0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sw done ACK d0", 64'(ack0), 64'h0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1);
        chk("sw ACK d2 six bubbles", 64'(ack2), 64'h1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sw done ACK d2", 64'(ack2), 64'h0);
        tick();

        // Reset in the middle of a drain aborts it.
        drive(1, 0, 0, 0, 0, 1, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("drain rst RESET_PR d0", 64'(rpr0), 64'hF);
        chk("drain rst ACK d0", 64'(ack0), 64'h0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("drain rst HOLD_PC d0", 64'(hpc0), 64'h0);
        chk("drain rst STALL d0", 64'(st0), 64'h0);
        tick();

        // Counter saturation on the 4-bit instance.
        for (int c = 0; c < 20; c++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("sat STALL d1", 64'(st1), 64'hF);
        chk("sat STALL d0", 64'(st0), 64'd20);
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 800; c++) begin
            drive(($urandom_range(0, 99) >= 3), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
                  ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
                  ($urandom_range(0, 99) < 20));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
